// File: rtl/rx_gate_ctrl_pkg.sv
// Shared definitions for the RX receive-window gating controller.
`ifndef RX_GATE_CTRL_PKG_SV
`define RX_GATE_CTRL_PKG_SV

// Slice of field i, each w bits wide, out of a flat packed vector.
`define RXG_FIELD(vec, i, w) vec[(i)*(w) +: (w)]

package rx_gate_ctrl_pkg;

  localparam int WIN_W_DEFAULT   = 16;
  localparam int WINDOWS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1
  } gate_state_t;

endpackage

`endif

// File: rtl/rx_trig_sync.sv
// Brings the external trigger into the clk domain and turns each rising
// edge into a single-cycle pulse.
module rx_trig_sync
  import rx_gate_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic trig_in,
  output logic trig_edge
);

  logic sync_1;
  logic sync_2;
  logic sync_3;

  // Two-flop synchroniser, one extra stage for edge history, registered pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_3    <= 1'b0;
      trig_edge <= 1'b0;
    end else begin
      sync_1    <= trig_in;
      sync_2    <= sync_1;
      sync_3    <= sync_2;
      trig_edge <= sync_2 & ~sync_3;
    end
  end

endmodule

// File: rtl/rx_gate_ctrl.sv
// Per-trigger sample counter that opens the RX FIFO write gate only for
// samples falling inside the programmed receive windows.
module rx_gate_ctrl
  import rx_gate_ctrl_pkg::*;
#(
  parameter int WINDOWS = WINDOWS_DEFAULT,
  parameter int WIN_W   = WIN_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     trig_in,
  input  logic                     rxstrobe,
  input  logic [WINDOWS*WIN_W-1:0] win_start,
  input  logic [WINDOWS*WIN_W-1:0] win_size,
  input  logic                     clear_status,
  output logic                     gate_enable,
  output logic                     frame_active,
  output logic [2:0]               win_idx,
  output logic [15:0]              frame_count,
  output logic                     missed_trig,
  output logic [WIN_W-1:0]         sample_idx
);

  localparam logic [WIN_W-1:0] IDX_MAX = '1;

  gate_state_t              state;
  logic                     trig_edge;
  logic                     first_cycle;
  logic [WINDOWS*WIN_W-1:0] sh_start;
  logic [WINDOWS*WIN_W-1:0] sh_size;
  logic [WIN_W:0]           last_end;
  logic [WIN_W:0]           last_end_next;
  logic [WIN_W-1:0]         next_idx;
  logic [WIN_W:0]           idx_wide;
  logic [WIN_W:0]           idx_inc_wide;
  logic [WIN_W:0]           sh_end [WINDOWS];
  logic [WINDOWS-1:0]       win_en;
  logic [WINDOWS-1:0]       hit_next;
  logic [WINDOWS-1:0]       hit_zero;
  logic [2:0]               next_win_idx;
  logic [2:0]               zero_win_idx;

  rx_trig_sync u_trig_sync (
    .clk       (clk),
    .reset     (reset),
    .trig_in   (trig_in),
    .trig_edge (trig_edge)
  );

  // The index saturates so a runaway frame can never wrap back into a window.
  assign idx_wide     = {1'b0, sample_idx};
  assign idx_inc_wide = idx_wide + (WIN_W+1)'(1);
  assign next_idx     = (sample_idx == IDX_MAX) ? sample_idx : sample_idx + WIN_W'(1);

  // Window ends are one bit wider so a window reaching past the top index
  // does not wrap around to a small end value.
  for (genvar i = 0; i < WINDOWS; i++) begin : g_win
    logic [WIN_W-1:0] s_start;
    logic [WIN_W-1:0] s_size;
    logic [WIN_W-1:0] l_start;
    logic [WIN_W-1:0] l_size;

    assign s_start     = `RXG_FIELD(sh_start, i, WIN_W);
    assign s_size      = `RXG_FIELD(sh_size, i, WIN_W);
    assign l_start     = `RXG_FIELD(win_start, i, WIN_W);
    assign l_size      = `RXG_FIELD(win_size, i, WIN_W);
    assign sh_end[i]   = {1'b0, s_start} + {1'b0, s_size};
    assign win_en[i]   = (s_size != '0);
    assign hit_next[i] = win_en[i] && (next_idx >= s_start) && ({1'b0, next_idx} < sh_end[i]);
    assign hit_zero[i] = (l_size != '0) && (l_start == '0);
  end

  // Lowest-numbered hit for win_idx, and the furthest end of any enabled window.
  always_comb begin
    next_win_idx  = '0;
    zero_win_idx  = '0;
    last_end_next = '0;
    for (int j = WINDOWS - 1; j >= 0; j--) begin
      if (hit_next[j]) next_win_idx = 3'(j);
      if (hit_zero[j]) zero_win_idx = 3'(j);
    end
    for (int j = 0; j < WINDOWS; j++) begin
      if (win_en[j] && (sh_end[j] > last_end_next)) last_end_next = sh_end[j];
    end
  end

  // Frame end is registered from the shadow copy, so it lags the latch by a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_end <= '0;
    else        last_end <= last_end_next;
  end

  // Gating FSM: accept a trigger, walk the sample index, drive the write gate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      first_cycle  <= 1'b0;
      sh_start     <= '0;
      sh_size      <= '0;
      sample_idx   <= '0;
      gate_enable  <= 1'b0;
      frame_active <= 1'b0;
      win_idx      <= '0;
      frame_count  <= '0;
      missed_trig  <= 1'b0;
    end else begin
      if (trig_edge && (state != IDLE)) missed_trig <= 1'b1;
      else if (clear_status)            missed_trig <= 1'b0;

      if (!enable) begin
        state        <= IDLE;
        first_cycle  <= 1'b0;
        gate_enable  <= 1'b0;
        frame_active <= 1'b0;
        win_idx      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (trig_edge) begin
              sh_start     <= win_start;
              sh_size      <= win_size;
              sample_idx   <= '0;
              gate_enable  <= |hit_zero;
              win_idx      <= zero_win_idx;
              frame_count  <= frame_count + 16'd1;
              first_cycle  <= 1'b1;
              frame_active <= 1'b1;
              state        <= COUNT;
            end
          end
          COUNT: begin
            first_cycle <= 1'b0;
            if (!first_cycle && (idx_wide >= last_end)) begin
              state        <= IDLE;
              gate_enable  <= 1'b0;
              frame_active <= 1'b0;
              win_idx      <= '0;
            end else if (rxstrobe) begin
              sample_idx <= next_idx;
              if (!first_cycle && (idx_inc_wide >= last_end)) begin
                state        <= IDLE;
                gate_enable  <= 1'b0;
                frame_active <= 1'b0;
                win_idx      <= '0;
              end else begin
                gate_enable <= |hit_next;
                win_idx     <= next_win_idx;
              end
            end
          end
          default: begin
            state        <= IDLE;
            gate_enable  <= 1'b0;
            frame_active <= 1'b0;
            win_idx      <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_gate_ctrl.sv
// Directed bench for rx_gate_ctrl: window gating, overlap, missed triggers,
// shadowed config, enable drop, top-of-range windows and async reset.
module tb_rx_gate_ctrl;

  localparam int WINDOWS = 4;
  localparam int WIN_W   = 16;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     enable = 1'b0;
  logic                     trig_in = 1'b0;
  logic                     rxstrobe = 1'b0;
  logic                     clear_status = 1'b0;
  logic [WINDOWS*WIN_W-1:0] win_start;
  logic [WINDOWS*WIN_W-1:0] win_size;
  logic                     gate_enable;
  logic                     frame_active;
  logic [2:0]               win_idx;
  logic [15:0]              frame_count;
  logic                     missed_trig;
  logic [WIN_W-1:0]         sample_idx;

  int cfg_start [WINDOWS];
  int cfg_size  [WINDOWS];
  int mdl_start [WINDOWS];
  int mdl_size  [WINDOWS];
  int num_checks = 0;
  int num_errors = 0;
  int exp_fc     = 0;
  int wr_count   = 0;

  rx_gate_ctrl #(.WINDOWS(WINDOWS), .WIN_W(WIN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .trig_in      (trig_in),
    .rxstrobe     (rxstrobe),
    .win_start    (win_start),
    .win_size     (win_size),
    .clear_status (clear_status),
    .gate_enable  (gate_enable),
    .frame_active (frame_active),
    .win_idx      (win_idx),
    .frame_count  (frame_count),
    .missed_trig  (missed_trig),
    .sample_idx   (sample_idx)
  );

  always #5 clk = ~clk;

  // Pack the per-window config arrays onto the flat ports.
  always_comb begin
    win_start = '0;
    win_size  = '0;
    for (int i = 0; i < WINDOWS; i++) begin
      win_start[i*WIN_W +: WIN_W] = cfg_start[i][WIN_W-1:0];
      win_size[i*WIN_W +: WIN_W]  = cfg_size[i][WIN_W-1:0];
    end
  end

  // Hard stop in case the run stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    num_checks++;
    if (obs !== exp_v) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic bit model_inwin(int k);
    for (int i = 0; i < WINDOWS; i++)
      if (mdl_size[i] != 0 && k >= mdl_start[i] && k < mdl_start[i] + mdl_size[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_win_idx(int k);
    for (int i = 0; i < WINDOWS; i++)
      if (mdl_size[i] != 0 && k >= mdl_start[i] && k < mdl_start[i] + mdl_size[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < WINDOWS; i++) begin
      cfg_start[i] = 0;
      cfg_size[i]  = 0;
    end
  endtask

  task automatic set_cfg(input int i, input int s, input int z);
    cfg_start[i] = s;
    cfg_size[i]  = z;
  endtask

  task automatic trig_pulse();
    trig_in = 1'b1;
    tick();
    tick();
    trig_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_frame();
    for (int i = 0; i < WINDOWS; i++) begin
      mdl_start[i] = cfg_start[i];
      mdl_size[i]  = cfg_size[i];
    end
    trig_pulse();
    exp_fc++;
    check_output("accept_active", frame_active, 1);
    check_output("accept_fc", frame_count, exp_fc);
    check_output("accept_idx0", sample_idx, 0);
  endtask

  task automatic strobe_once();
    rxstrobe = 1'b1;
    if (gate_enable) wr_count++;
    tick();
    rxstrobe = 1'b0;
  endtask

  task automatic run_strobes(input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      check_output($sformatf("idx@%0d", k), sample_idx, k);
      check_output($sformatf("gate@%0d", k), gate_enable, model_inwin(k));
      check_output($sformatf("widx@%0d", k), win_idx, model_win_idx(k));
      strobe_once();
    end
  endtask

  initial begin
    clear_cfg();
    for (int i = 0; i < WINDOWS; i++) begin
      mdl_start[i] = 0;
      mdl_size[i]  = 0;
    end
    repeat (3) tick();
    check_output("rst_gate", gate_enable, 0);
    check_output("rst_active", frame_active, 0);
    check_output("rst_widx", win_idx, 0);
    check_output("rst_fc", frame_count, 0);
    check_output("rst_missed", missed_trig, 0);
    check_output("rst_idx", sample_idx, 0);
    reset  = 1'b1;
    enable = 1'b1;
    tick();

    $display("[TB] single window 10..13");
    clear_cfg();
    set_cfg(0, 10, 4);
    start_frame();
    wr_count = 0;
    run_strobes(0, 14);
    check_output("t1_end_active", frame_active, 0);
    check_output("t1_end_idx", sample_idx, 14);
    check_output("t1_end_gate", gate_enable, 0);
    repeat (6) strobe_once();
    check_output("t1_idle_idx", sample_idx, 14);
    check_output("t1_writes", wr_count, 4);

    $display("[TB] overlapping windows 2..4 and 4..7");
    clear_cfg();
    set_cfg(0, 2, 3);
    set_cfg(1, 4, 4);
    start_frame();
    wr_count = 0;
    run_strobes(0, 8);
    check_output("t2_end_active", frame_active, 0);
    check_output("t2_end_idx", sample_idx, 8);
    check_output("t2_writes", wr_count, 6);

    $display("[TB] missed trigger and clear_status");
    clear_cfg();
    set_cfg(0, 10, 40);
    start_frame();
    run_strobes(0, 5);
    trig_pulse();
    check_output("t3_missed_set", missed_trig, 1);
    check_output("t3_fc_hold", frame_count, exp_fc);
    check_output("t3_still_active", frame_active, 1);
    check_output("t3_idx_hold", sample_idx, 5);
    run_strobes(5, 45);
    check_output("t3_end_active", frame_active, 0);
    check_output("t3_end_idx", sample_idx, 50);
    check_output("t3_missed_sticky", missed_trig, 1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check_output("t3_missed_clr", missed_trig, 0);
    start_frame();
    trig_in = 1'b1;
    tick();
    tick();
    trig_in = 1'b0;
    tick();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check_output("t3_set_wins", missed_trig, 1);
    check_output("t3_fc_hold2", frame_count, exp_fc);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check_output("t3_missed_clr2", missed_trig, 0);

    $display("[TB] config change during a frame");
    clear_cfg();
    set_cfg(0, 10, 4);
    start_frame();
    run_strobes(0, 2);
    cfg_start[0] = 30;
    run_strobes(2, 12);
    check_output("t4_end_active", frame_active, 0);
    start_frame();
    wr_count = 0;
    run_strobes(0, 34);
    check_output("t4_end2_active", frame_active, 0);
    check_output("t4_writes", wr_count, 4);

    $display("[TB] enable drop mid-window");
    clear_cfg();
    set_cfg(0, 10, 4);
    start_frame();
    run_strobes(0, 11);
    check_output("t5_gate_pre", gate_enable, 1);
    enable = 1'b0;
    tick();
    check_output("t5_gate_off", gate_enable, 0);
    check_output("t5_active_off", frame_active, 0);
    check_output("t5_idx_hold", sample_idx, 11);
    enable = 1'b1;
    repeat (3) strobe_once();
    check_output("t5_idx_ignored", sample_idx, 11);
    check_output("t5_gate_idle", gate_enable, 0);
    check_output("t5_fc", frame_count, exp_fc);

    $display("[TB] all windows disabled");
    clear_cfg();
    start_frame();
    tick();
    tick();
    check_output("t6_zero_active", frame_active, 0);
    check_output("t6_zero_gate", gate_enable, 0);

    $display("[TB] window at top of index range, then async reset");
    clear_cfg();
    set_cfg(0, 65534, 4);
    start_frame();
    rxstrobe = 1'b1;
    repeat (65534) tick();
    rxstrobe = 1'b0;
    check_output("t7_idx_65534", sample_idx, 65534);
    check_output("t7_gate_65534", gate_enable, model_inwin(65534));
    check_output("t7_active", frame_active, 1);
    strobe_once();
    check_output("t7_idx_65535", sample_idx, 65535);
    check_output("t7_gate_65535", gate_enable, model_inwin(65535));
    strobe_once();
    check_output("t7_idx_sat", sample_idx, 65535);
    check_output("t7_gate_sat", gate_enable, 1);
    #2;
    reset = 1'b0;
    #1;
    check_output("t7_rst_gate", gate_enable, 0);
    check_output("t7_rst_active", frame_active, 0);
    check_output("t7_rst_idx", sample_idx, 0);
    check_output("t7_rst_fc", frame_count, 0);
    check_output("t7_rst_widx", win_idx, 0);
    check_output("t7_rst_missed", missed_trig, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
